// File: rtl/uart_time_cmd_ctrl.sv
// uart_time_cmd_ctrl
// Parses ASCII set-time frames 'T' H H M M CR coming from the UART receiver.
// A frame that passes the range check produces a one-cycle load of hour and
// minute into the timekeeper. Every frame is answered with ACK or NAK through
// a valid/ready transmit handshake. A stalled frame times out.
module uart_time_cmd_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 200000000,
   parameter logic [7:0]  ACK_CHAR       = 8'h4B,
   parameter logic [7:0]  NAK_CHAR       = 8'h45
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic [4:0] set_hour,
   output logic [5:0] set_min,
   output logic       set_load,
   output logic [7:0] tx_data,
   output logic       tx_valid,
   input  logic       tx_ready,
   output logic       busy,
   output logic [7:0] nak_count
);

   localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   localparam logic [7:0] CH_T  = 8'h54;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_LF = 8'h0A;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      H10  = 3'd1,
      H1   = 3'd2,
      M10  = 3'd3,
      M1   = 3'd4,
      EOL  = 3'd5,
      LOAD = 3'd6,
      RESP = 3'd7
   } state_t;

   state_t           state_r;
   logic [3:0]       h10_r;
   logic [3:0]       h1_r;
   logic [3:0]       m10_r;
   logic [3:0]       m1_r;
   logic [CNT_W-1:0] cnt_r;

   logic       rx_byte_s;
   logic       is_t_s;
   logic       is_cr_s;
   logic       is_digit_s;
   logic [6:0] hour_s;
   logic [6:0] min_s;
   logic       frame_ok_s;
   logic [7:0] nak_next_s;

   // Byte classification, frame value reconstruction and saturating NAK increment.
   always_comb begin
      rx_byte_s  = 1'b0;
      is_t_s     = 1'b0;
      is_cr_s    = 1'b0;
      is_digit_s = 1'b0;
      hour_s     = 7'd0;
      min_s      = 7'd0;
      frame_ok_s = 1'b0;
      nak_next_s = nak_count;

      // LF is transparent everywhere: it neither advances nor refreshes the timeout.
      rx_byte_s  = rx_valid && (rx_data != CH_LF);
      is_t_s     = (rx_data == CH_T);
      is_cr_s    = (rx_data == CH_CR);
      is_digit_s = (rx_data >= 8'h30) && (rx_data <= 8'h39);

      // 7-bit results hold up to 99, so out-of-range values are never wrapped into range.
      hour_s     = ({3'b000, h10_r} * 7'd10) + {3'b000, h1_r};
      min_s      = ({3'b000, m10_r} * 7'd10) + {3'b000, m1_r};
      frame_ok_s = (hour_s <= 7'd23) && (min_s <= 7'd59);

      if (nak_count == 8'hFF) begin
         nak_next_s = nak_count;
      end else begin
         nak_next_s = nak_count + 8'd1;
      end
   end

   // Frame sequencer with registered load, response and error-count outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= IDLE;
         h10_r     <= 4'd0;
         h1_r      <= 4'd0;
         m10_r     <= 4'd0;
         m1_r      <= 4'd0;
         cnt_r     <= '0;
         set_hour  <= 5'd0;
         set_min   <= 6'd0;
         set_load  <= 1'b0;
         tx_data   <= 8'h00;
         tx_valid  <= 1'b0;
         nak_count <= 8'h00;
      end else begin
         set_load <= 1'b0;
         case (state_r)
            IDLE: begin
               cnt_r    <= '0;
               tx_valid <= 1'b0;
               if (rx_byte_s && is_t_s) begin
                  state_r <= H10;
                  h10_r   <= 4'd0;
                  h1_r    <= 4'd0;
                  m10_r   <= 4'd0;
                  m1_r    <= 4'd0;
               end else begin
                  state_r <= IDLE;
               end
            end

            H10, H1, M10, M1, EOL: begin
               if (rx_byte_s) begin
                  // Any real byte refreshes the inter-byte timeout, even at terminal count.
                  cnt_r <= '0;
                  if (is_t_s) begin
                     // A new 'T' silently restarts the frame.
                     state_r <= H10;
                     h10_r   <= 4'd0;
                     h1_r    <= 4'd0;
                     m10_r   <= 4'd0;
                     m1_r    <= 4'd0;
                  end else if (is_digit_s && (state_r != EOL)) begin
                     case (state_r)
                        H10: begin
                           h10_r   <= rx_data[3:0];
                           state_r <= H1;
                        end
                        H1: begin
                           h1_r    <= rx_data[3:0];
                           state_r <= M10;
                        end
                        M10: begin
                           m10_r   <= rx_data[3:0];
                           state_r <= M1;
                        end
                        M1: begin
                           m1_r    <= rx_data[3:0];
                           state_r <= EOL;
                        end
                        default: begin
                           state_r <= IDLE;
                        end
                     endcase
                  end else if (is_cr_s && (state_r == EOL)) begin
                     if (frame_ok_s) begin
                        // The load strobe and values appear together during LOAD.
                        state_r  <= LOAD;
                        set_load <= 1'b1;
                        set_hour <= hour_s[4:0];
                        set_min  <= min_s[5:0];
                     end else begin
                        state_r   <= RESP;
                        tx_data   <= NAK_CHAR;
                        tx_valid  <= 1'b1;
                        nak_count <= nak_next_s;
                     end
                  end else begin
                     state_r   <= RESP;
                     tx_data   <= NAK_CHAR;
                     tx_valid  <= 1'b1;
                     nak_count <= nak_next_s;
                  end
               end else if (cnt_r == CNT_LAST) begin
                  // Abandoned frame: drop back without a response, but count it.
                  state_r   <= IDLE;
                  cnt_r     <= '0;
                  nak_count <= nak_next_s;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end

            LOAD: begin
               cnt_r    <= '0;
               state_r  <= RESP;
               tx_data  <= ACK_CHAR;
               tx_valid <= 1'b1;
            end

            RESP: begin
               // Received bytes are dropped here; the response is held until accepted.
               cnt_r <= '0;
               if (tx_ready) begin
                  tx_valid <= 1'b0;
                  state_r  <= IDLE;
               end else begin
                  tx_valid <= 1'b1;
                  state_r  <= RESP;
               end
            end

            default: begin
               cnt_r    <= '0;
               tx_valid <= 1'b0;
               state_r  <= IDLE;
            end
         endcase
      end
   end

   assign busy = (state_r != IDLE);

endmodule

// File: doc/uart_time_cmd_ctrl.md
Name: uart_time_cmd_ctrl

Overview:
Command sequencer between the UART byte receiver and the timekeeping counter of the digital clock. It parses ASCII set-time frames of the form 'T' H H M M CR and range-checks the result. On a valid frame it issues a one-cycle load of hour and minute into the timekeeper. Every frame is answered with an ACK or NAK byte through a valid/ready transmit handshake. It replaces ad-hoc digit counting with a framed, validated, timeout-protected protocol.

Parameters:
TIMEOUT_CYCLES, 200000000, maximum clk cycles allowed between two bytes of one frame (2 s at 100 MHz); counter width is clog2(TIMEOUT_CYCLES).
ACK_CHAR, 8'h4B, byte sent after a successful load ('K').
NAK_CHAR, 8'h45, byte sent after a rejected frame ('E').

Ports:
clk  in  1  system clock; all logic on rising edge.
rst  in  1  synchronous, active-high reset.
rx_data  in  8  received byte; valid only when rx_valid=1.
rx_valid  in  1  one-cycle strobe per received byte.
set_hour  out  5  hour to load, 0..23.
set_min  out  6  minute to load, 0..59.
set_load  out  1  one-cycle strobe; timekeeper loads set_hour/set_min and clears its seconds.
tx_data  out  8  response byte.
tx_valid  out  1  response pending.
tx_ready  in  1  transmitter accepts tx_data in a cycle where tx_valid=1 and tx_ready=1.
busy  out  1  high in every state except IDLE.
nak_count  out  8  saturating count of NAKs plus timeouts.

Behaviour:
- Reset values: set_hour=0, set_min=0, set_load=0, tx_data=0, tx_valid=0, nak_count=0. The FSM returns to IDLE, digit registers clear, and the timeout counter clears. Reset overrides everything, including a pending response, which is dropped.
- FSM states: IDLE, H10, H1, M10, M1, EOL, LOAD, RESP.
- IDLE: rx 'T' (0x54) moves to H10. Every other byte is ignored.
- Digit states H10→H1→M10→M1→EOL: on rx '0'..'9' (0x30..0x39), store the digit (rx_data-0x30, 4 bits) and advance.
- EOL: on rx CR (0x0D), run validation.
- LF (0x0A) is ignored in every state. It does not advance the FSM and does not reload the timeout counter.
- 'T' in H10..EOL restarts the frame: go to H10, clear the digits, send no response.
- Any other byte in H10..EOL, including a digit arriving in EOL, sends the FSM to RESP with tx_data=NAK_CHAR.
- Validation, using 7-bit arithmetic:
  - hour = h10*10 + h1, min = m10*10 + m1 (each 0..99, no truncation before compare).
  - Valid iff hour ≤ 23 and min ≤ 59.
  - Valid: next state LOAD. Invalid: RESP with NAK.
- LOAD (exactly one cycle): set_load=1; set_hour and set_min (truncated to 5 and 6 bits) are updated in the same cycle and hold until the next load. Next state is RESP with tx_data=ACK_CHAR.
- Latency:
  - CR accepted in cycle N → set_load=1 in N+1, tx_valid=1 from N+2.
  - Rejected byte in cycle N → tx_valid=1 from N+1.
- RESP:
  - tx_valid stays 1 and tx_data is stable until the handshake; tx_valid=1 and tx_ready=1 in one cycle completes the transfer.
  - In the cycle after the handshake tx_valid=0 and the state is IDLE.
  - rx bytes arriving during LOAD or RESP are dropped, including 'T'.
  - tx_valid is never high outside RESP.
- Timeout:
  - The counter clears on every non-LF rx byte and increments each cycle while in H10..EOL.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid that cycle: go to IDLE, send no response, nak_count+1.
  - If rx_valid coincides with the terminal count, the byte wins and the timeout is discarded.
  - The counter holds at 0 in IDLE, LOAD and RESP.
- nak_count increments on each NAK entry into RESP and on each timeout. It saturates at 255.
- busy=1 in all states except IDLE.

Test Plan:
- Reset, then rx "T1230\r" with tx_ready=1 → exactly one set_load pulse one cycle after CR with set_hour=12, set_min=30; tx_data=0x4B on the next cycle; busy returns to 0.
- rx "T2460\r" → no set_load; NAK 0x45 is sent; nak_count=1; set_hour/set_min keep their previous values.
- rx "T12\n3x" → LF is ignored; NAK is sent the cycle after 'x'; rx "T0959\r" then loads 09:59.
- rx "T12" then idle for TIMEOUT_CYCLES (bench overrides to 100) → back to IDLE, tx_valid never asserted, nak_count+1; a byte arriving exactly at terminal count keeps the frame alive.
- ACK pending with tx_ready=0 for 20 cycles while rx sends "T0000\r" → tx_valid and tx_data=0x4B stay stable, the rx bytes are dropped, and there is no second set_load; raising tx_ready completes one transfer.
- Assert rst during M10 and again during RESP → next cycle all outputs are at reset values and the state is IDLE; a fresh "T2359\r" loads 23:59.
